// File: rtl/coin_accumulator.sv
// Coin-count producer for the vending display path: debounces the coin switch,
// accumulates coins into cs, and sequences purchase and coin-return pulses.
module coin_accumulator #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PRICE           = 3,
  parameter int unsigned REFUND_GAP      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_in,
  input  logic       buy,
  input  logic       cancel,
  output logic [2:0] cs,
  output logic       dispense,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       busy
);

  localparam int unsigned CW  = 3;
  localparam int unsigned DBW = 8;
  localparam int unsigned GW  = 4;

  localparam logic [CW-1:0]  CS_MAX  = CW'(7);
  localparam logic [CW-1:0]  PRICE_C = CW'(PRICE);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0]  GAP     = GW'(REFUND_GAP);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  logic           sync1, sync2;
  logic           deb, deb_q;
  logic [DBW-1:0] db_cnt;
  logic           coin_event_c;

  state_t         state, state_n;
  logic [GW-1:0]  gap_cnt, gap_n;
  logic [CW-1:0]  cs_n;
  logic           dispense_n, change_n, reject_n, busy_n;

  // Synchronize and debounce coin_in; the debounced level only moves after a run of stable samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      deb    <= 1'b0;
      deb_q  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= coin_in;
      sync2 <= sync1;
      deb_q <= deb;
      if (sync2 == deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        deb    <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  assign coin_event_c = deb & ~deb_q;

  // Next-state and next-output decode; every output below is registered.
  always_comb begin
    state_n    = state;
    cs_n       = cs;
    gap_n      = gap_cnt;
    dispense_n = 1'b0;
    change_n   = 1'b0;
    reject_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cancel && (cs != '0)) begin
          state_n  = ST_RETURN;
          gap_n    = '0;
          reject_n = coin_event_c;
        end else if (buy && (cs >= PRICE_C)) begin
          state_n    = ST_VEND;
          cs_n       = cs - PRICE_C;
          dispense_n = 1'b1;
          reject_n   = coin_event_c;
        end else if (coin_event_c) begin
          if (cs == CS_MAX) begin
            reject_n = 1'b1;
          end else begin
            cs_n = cs + CW'(1);
          end
        end
      end
      ST_VEND: begin
        reject_n = coin_event_c;
        gap_n    = '0;
        state_n  = (cs != '0) ? ST_RETURN : ST_IDLE;
      end
      ST_RETURN: begin
        reject_n = coin_event_c;
        if (cs == '0) begin
          state_n = ST_IDLE;
        end else if (gap_cnt == '0) begin
          change_n = 1'b1;
          cs_n     = cs - CW'(1);
          gap_n    = GAP;
        end else begin
          gap_n = gap_cnt - GW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      gap_cnt      <= '0;
      cs           <= '0;
      dispense     <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      gap_cnt      <= gap_n;
      cs           <= cs_n;
      dispense     <= dispense_n;
      change_pulse <= change_n;
      coin_reject  <= reject_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: doc/coin_accumulator.md
Name: coin_accumulator

Overview:
- Producer side of the coin-count display path. Debounces the raw coin switch and accumulates inserted coins.
- Drives the 3-bit coin-count state `cs` (0..7) that the 7-segment coin display decoder consumes.
- Handles purchase (subtract price, dispense) and cancel/change (return coins one pulse at a time).
- Sits between the front-panel inputs and the display and actuator outputs of the vending controller.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a new coin_in level (1..255).
- PRICE, 3: item price in coins (1..7).
- REFUND_GAP, 2: idle cycles between consecutive change_pulse assertions (0..15).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coin_in  in  1  raw coin switch, asynchronous, bouncy; high = coin present.
- buy  in  1  synchronous purchase request, sampled every cycle.
- cancel  in  1  synchronous cancel request, sampled every cycle.
- cs  out  3  current coin count 0..7, registered; feeds the display decoder.
- dispense  out  1  one-cycle pulse, item released.
- change_pulse  out  1  one-cycle pulse per coin returned.
- coin_reject  out  1  one-cycle pulse, accepted coin event not counted.
- busy  out  1  high in VEND or RETURN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - cs=0, dispense=0, change_pulse=0, coin_reject=0, busy=0.
  - State=IDLE, synchronizer flops=0, debounced level=0, debounce counter=0, gap counter=0.
  - Release is synchronous to clk. Reset asserted mid-vend or mid-refund abandons the operation with no further pulses.
- Input conditioning:
  - coin_in passes through a 2-flop synchronizer.
  - The debounce counter increments while the synchronized value differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter clears.
  - A 0->1 transition of the debounced level creates a single-cycle coin event.
  - Latency: a clean rise held steady makes cs update on the 3+DEBOUNCE_CYCLES-th rising edge after the first edge that samples coin_in=1.
  - Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no event.
- FSM states: IDLE, VEND, RETURN.
- IDLE, evaluated in priority order each cycle:
  1. cancel=1 and cs>0: go to RETURN. A coin event this cycle gets coin_reject.
  2. buy=1 and cs>=PRICE: next cycle cs=cs-PRICE, dispense=1, state=VEND. A coin event this cycle gets coin_reject.
  3. Coin event with cs<7: cs=cs+1.
  4. Coin event with cs==7: coin_reject=1, cs holds (saturation, no wrap).
  - buy with cs<PRICE is ignored, no outputs.
  - cancel with cs==0 is ignored.
- VEND (one cycle):
  - If cs>0 go to RETURN, else go to IDLE.
  - buy and cancel are ignored. A coin event gets coin_reject.
- RETURN:
  - The first change_pulse is asserted the cycle after entry.
  - Each change_pulse cycle decrements cs by 1 in the same registered update.
  - After each pulse, REFUND_GAP idle cycles follow before the next pulse.
  - The state returns to IDLE in the cycle after the pulse that brings cs to 0; no trailing gap.
  - buy and cancel are ignored. Coin events get coin_reject.
- Output rules:
  - busy is registered and high exactly while state is VEND or RETURN.
  - dispense, change_pulse and coin_reject are registered and never wider than one cycle.
- Arithmetic:
  - cs is 3-bit unsigned and never wraps.
  - Subtraction occurs only when cs>=PRICE.

Test Plan:
- Reset, then 3 clean coin rises (each held 10 cycles, low 10 cycles, DEBOUNCE_CYCLES=4) -> cs steps 0,1,2,3; each increment lands 7 edges after the first high sample; coin_reject never asserted.
- Bouncy coin_in: 1-cycle high, 1 low, 2 high, 1 low, then steady high 10 cycles -> exactly one increment; glitch-only stimulus (pulses ≤3 cycles) -> cs unchanged.
- cs=5, buy for 1 cycle (PRICE=3) -> next cycle cs=2 and dispense=1; busy high; change_pulse at +2 and +5 cycles (REFUND_GAP=2) with cs=1 then 0; IDLE and busy=0 one cycle after the last pulse.
- cs=2, buy -> ignored, no dispense; then buy and cancel asserted together -> RETURN with 2 change_pulses, no dispense.
- Insert 8 coins -> cs saturates at 7; the 8th event gives coin_reject=1 and cs stays 7; a coin inserted during RETURN also gives coin_reject.
- rst_n pulled low mid-RETURN at cs=3 -> all outputs 0 immediately (asynchronously); after release, no residual change_pulse and cs=0.
